// File: rtl/dec_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined N-to-2^N decoder.
package dec_pipe_pkg;

    // Output encoding selected per transaction
    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

    // Supported input code widths
    localparam int IN_W_MIN = 2;
    localparam int IN_W_MAX = 10;

    // Number of 2-bit predecode groups for a given input width
    function automatic int group_count(input int in_w);
        return in_w / 2;
    endfunction

    // True when the input width can be split evenly into 2-bit groups and is in range
    function automatic bit in_w_legal(input int in_w);
        return ((in_w % 2) == 0) && (in_w >= IN_W_MIN) && (in_w <= IN_W_MAX);
    endfunction

endpackage

// File: rtl/dec_2_4.sv
// Combinational 2-to-4 predecoder: one-hot of a 2-bit group.
module dec_2_4 (
    input  logic [1:0] code_i,
    output logic [3:0] dec_o
);

    // One bit set at the position selected by the 2-bit code
    always_comb begin
        dec_o = 4'b0000;
        dec_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/dec_pipe_n.sv
// Two-stage pipelined N-to-2^N decoder with valid/ready handshake.
// Stage 1 registers per-group predecodes; stage 2 combines them into the
// full one-hot or thermometer word. Both stages stall together on backpressure.
module dec_pipe_n
    import dec_pipe_pkg::*;
#(
    parameter int IN_W  = 6,
    parameter int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int GROUPS = group_count(IN_W);
    localparam int PRE_W  = 4 * GROUPS;

    // Reject unsupported widths at elaboration
    if (!in_w_legal(IN_W)) begin : g_bad_in_w
        $error("dec_pipe_n: IN_W must be even and within 2..10");
    end
    if (OUT_W != (2**IN_W)) begin : g_bad_out_w
        $error("dec_pipe_n: OUT_W must equal 2**IN_W");
    end

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [PRE_W-1:0] pre_q,      pre_d;
    logic             mode_q,     mode_d;
    logic             en_q,       en_d;
    logic [IN_W-1:0]  code_q,     code_d;

    // Stage 2 state
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;

    logic             stall;
    logic [PRE_W-1:0] pre_in;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;

    // Whole pipe freezes only when a result is held and not taken
    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    genvar gi, gj;

    // Predecode each 2-bit slice of the incoming code
    for (gi = 0; gi < GROUPS; gi++) begin : g_pre
        dec_2_4 u_dec_2_4 (
            .code_i (in_code[2*gi+1:2*gi]),
            .dec_o  (pre_in[4*gi+3:4*gi])
        );
    end

    // Output bit k is the AND of the predecode lines its own group digits select;
    // thermometer bit k is set for every k up to the captured code.
    for (gi = 0; gi < OUT_W; gi++) begin : g_bit
        logic [GROUPS-1:0] sel;
        for (gj = 0; gj < GROUPS; gj++) begin : g_grp
            localparam int LINE = 4*gj + ((gi >> (2*gj)) % 4);
            assign sel[gj] = pre_q[LINE];
        end
        assign onehot[gi] = &sel;
        assign therm[gi]  = (IN_W'(gi) <= code_q);
    end

    // Next-state for both stages: hold on stall, otherwise advance (bubbles included)
    always_comb begin
        s1_valid_d  = s1_valid_q;
        pre_d       = pre_q;
        mode_d      = mode_q;
        en_d        = en_q;
        code_d      = code_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                pre_d  = pre_in;
                mode_d = in_mode;
                en_d   = in_en;
                code_d = in_code;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (!en_q) begin
                    out_data_d = '0;
                end else if (mode_q == MODE_THERM) begin
                    out_data_d = therm;
                end else begin
                    out_data_d = onehot;
                end
            end
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            pre_q       <= '0;
            mode_q      <= 1'b0;
            en_q        <= 1'b0;
            code_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            pre_q       <= pre_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            code_q      <= code_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_dec_pipe_n.sv
// Directed, table-driven bench for dec_pipe_n (IN_W=6 main instance, IN_W=2 second instance).
module tb_dec_pipe_n;

    logic        clk = 1'b0;
    logic        rst_n;

    // IN_W = 6 instance
    logic        in_valid, in_ready, in_en, in_mode, out_valid, out_ready;
    logic [5:0]  in_code;
    logic [63:0] out_data;

    // IN_W = 2 instance
    logic        in_valid2, in_ready2, in_en2, in_mode2, out_valid2, out_ready2;
    logic [1:0]  in_code2;
    logic [3:0]  out_data2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  code;
        logic        mode;
        logic        en;
        logic [63:0] exp;
    } vec_t;

    localparam int NV = 72;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    dec_pipe_n #(.IN_W(6)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    dec_pipe_n #(.IN_W(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_code   (in_code2),
        .in_en     (in_en2),
        .in_mode   (in_mode2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table: 64-code one-hot sweep, then thermometer, enable-low and mixed-mode entries
        for (int k = 0; k < 64; k++) begin
            tbl[k] = '{code: 6'(k), mode: 1'b0, en: 1'b1, exp: (64'h1 << k)};
        end
        tbl[64] = '{code: 6'd0,  mode: 1'b1, en: 1'b1, exp: 64'h0000_0000_0000_0001};
        tbl[65] = '{code: 6'd5,  mode: 1'b1, en: 1'b1, exp: 64'h0000_0000_0000_003F};
        tbl[66] = '{code: 6'd63, mode: 1'b1, en: 1'b1, exp: 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[67] = '{code: 6'd17, mode: 1'b0, en: 1'b0, exp: 64'h0000_0000_0000_0000};
        tbl[68] = '{code: 6'd17, mode: 1'b1, en: 1'b0, exp: 64'h0000_0000_0000_0000};
        tbl[69] = '{code: 6'd2,  mode: 1'b0, en: 1'b1, exp: 64'h0000_0000_0000_0004};
        tbl[70] = '{code: 6'd40, mode: 1'b1, en: 1'b1, exp: 64'h0000_01FF_FFFF_FFFF};
        tbl[71] = '{code: 6'd63, mode: 1'b0, en: 1'b1, exp: 64'h8000_0000_0000_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0; in_code  = '0; in_en  = 1'b1; in_mode  = 1'b0; out_ready  = 1'b1;
        in_valid2 = 1'b0; in_code2 = '0; in_en2 = 1'b1; in_mode2 = 1'b0; out_ready2 = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset out_data",  out_data,       64'h0);
        chk("reset in_ready",  64'(in_ready),  64'h1);
        chk("reset out_valid2", 64'(out_valid2), 64'h0);
        rst_n = 1'b1;
        tick();

        // Streamed table: vector t presented before edge t appears right after edge t+1
        for (int t = 0; t <= NV; t++) begin
            if (t < NV) begin
                in_valid = 1'b1;
                in_code  = tbl[t].code;
                in_mode  = tbl[t].mode;
                in_en    = tbl[t].en;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (t >= 1) begin
                chk($sformatf("vec%0d valid", t-1), 64'(out_valid), 64'h1);
                chk($sformatf("vec%0d code=%0d mode=%0d en=%0d data", t-1, tbl[t-1].code,
                              tbl[t-1].mode, tbl[t-1].en), out_data, tbl[t-1].exp);
            end else begin
                chk("first accept, not yet out", 64'(out_valid), 64'h0);
            end
        end
        tick();
        chk("stream drained valid", 64'(out_valid), 64'h0);

        // Backpressure: codes 3,4,5 with a 3-cycle stall once 3 is at the output
        in_valid = 1'b1; in_en = 1'b1; in_mode = 1'b0;
        in_code = 6'd3; tick();
        in_code = 6'd4; tick();
        chk("bp first out valid", 64'(out_valid), 64'h1);
        chk("bp first out data",  out_data,       64'h8);
        in_code = 6'd5; out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid = (s != 1);   // upstream drops valid mid-stall
            #1;
            chk($sformatf("bp stall%0d in_ready", s), 64'(in_ready), 64'h0);
            tick();
            chk($sformatf("bp stall%0d valid", s), 64'(out_valid), 64'h1);
            chk($sformatf("bp stall%0d data", s),  out_data,       64'h8);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        chk("bp second valid", 64'(out_valid), 64'h1);
        chk("bp second data",  out_data,       64'h10);
        tick();
        chk("bp third valid", 64'(out_valid), 64'h1);
        chk("bp third data",  out_data,       64'h20);
        tick();
        chk("bp no duplicate", 64'(out_valid), 64'h0);

        // Reset with codes 10 and 11 in flight
        in_valid = 1'b1; in_code = 6'd10; tick();
        in_code = 6'd11; tick();
        chk("rst full pipe data", out_data, 64'h400);
        in_valid = 1'b0; rst_n = 1'b0; tick();
        chk("rst mid valid", 64'(out_valid), 64'h0);
        chk("rst mid data",  out_data,       64'h0);
        rst_n = 1'b1; tick();
        chk("rst code11 dropped", 64'(out_valid), 64'h0);
        in_valid = 1'b1; in_code = 6'd20; tick();
        chk("post-rst latency gap", 64'(out_valid), 64'h0);
        in_valid = 1'b0; tick();
        chk("post-rst valid", 64'(out_valid), 64'h1);
        chk("post-rst data",  out_data,       64'h0000_0000_0010_0000);
        tick();
        chk("post-rst drained", 64'(out_valid), 64'h0);

        // Mixed modes back-to-back on the IN_W=2 instance
        in_valid2 = 1'b1; in_code2 = 2'd2; in_mode2 = 1'b0; tick();
        in_code2 = 2'd2; in_mode2 = 1'b1; tick();
        chk("w2 onehot 2", 64'(out_data2), 64'h4);
        in_code2 = 2'd3; in_mode2 = 1'b1; tick();
        chk("w2 therm 2",  64'(out_data2), 64'h7);
        in_valid2 = 1'b0; tick();
        chk("w2 therm 3",  64'(out_data2), 64'hF);
        chk("w2 therm 3 valid", 64'(out_valid2), 64'h1);
        tick();
        chk("w2 drained", 64'(out_valid2), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_pipe_n.md
Name: dec_pipe_n

Overview:
- Parametrised, pipelined N-to-2^N decoder with a valid/ready stream handshake.
- Stage 1 splits the input into 2-bit groups, predecodes each group to 4 bits and registers the result.
- Stage 2 combines the group predecodes into the 2^N output and registers it.
- Adds per-transaction enable and a thermometer mode. Used as an address/row-select decoder in wide-fanout datapaths.

Parameters:
- IN_W, 6, input code width; must be even, legal range 2..10.
- OUT_W, 2**IN_W, output width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream holds a transaction.
- in_ready  output  1  block accepts when in_valid && in_ready.
- in_code  input  IN_W  code to decode.
- in_en  input  1  0 forces an all-zero result (the transaction is still carried through).
- in_mode  input  1  0 = one-hot, 1 = thermometer.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  OUT_W  decoded result.

Behaviour:
- Reset: sampled on rising clk while rst_n=0.
  - Clears s1_valid, out_valid and out_data to 0, and all stage-1 registers to 0.
  - Reset overrides any handshake in the same cycle.
  - In-flight transactions are discarded, never emitted.
- Stall and advance:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - When stall=0, both stages advance every cycle and bubbles (valid=0) propagate.
  - When stall=1, all registers hold.
- Stage 1 on advance:
  - s1_valid <= in_valid.
  - If in_valid: register the predecode vector, in_mode, in_en and raw in_code.
  - The predecode vector holds IN_W/2 groups of 4 bits. Group g = one-hot of in_code[2g+1:2g].
- Stage 2 on advance:
  - out_valid <= s1_valid.
  - If s1_valid, out_data loads:
    - en=0: all zeros.
    - mode=0: bit k = AND over groups g of pre[g][k[2g+1:2g]]. Exactly one bit set, at index in_code.
    - mode=1: bit k = 1 for all k <= in_code. The result is never all-zero.
  - If s1_valid=0, out_data holds its previous value; it is only meaningful while out_valid=1.
- Timing and throughput:
  - Latency: 2 cycles, accept edge to out_valid, with no stall.
  - Throughput: 1 transaction/cycle with out_ready held high.
- Boundaries:
  - in_code=0: one-hot gives out_data=1; thermometer gives 1.
  - in_code=2^IN_W-1: one-hot gives MSB only; thermometer gives all ones.
  - Simultaneous accept and emit in one cycle is legal (full pipe, out_ready=1).
  - in_valid may drop during a stall; no transaction is lost or duplicated.
  - mode and en are captured per transaction; mixing modes back-to-back is legal.
- No combinational path from in_* to out_*; only out_ready -> in_ready is combinational.

Decomposition:
- Package dec_pipe_pkg holds:
  - MODE_ONEHOT=1'b0 and MODE_THERM=1'b1.
  - Function for group count IN_W/2.
  - Elaboration check that IN_W is even and within 2..10.
- One sub-module: dec_2_4, a combinational 2-to-4 predecoder instantiated IN_W/2 times via generate in stage 1.
- Pipeline registers and handshake stay in the top module.

Test Plan:
1. Sweep with IN_W=6, out_ready=1, mode=0, en=1: in_code 0..63 on consecutive cycles -> out_data = 1<<k, 2 cycles after each accept, one result per cycle, 64 results total.
2. Thermometer mode: in_code=0, 5, 63 with mode=1 -> out_data = 64'h1, 64'h3F, 64'hFFFF_FFFF_FFFF_FFFF.
3. Enable low: in_code=17, en=0 -> out_valid pulses and out_data=0.
4. Backpressure: stream codes 3, 4, 5 and drop out_ready for 3 cycles once out_valid=1:
   - in_ready=0 during the stall;
   - out_data holds 1<<3;
   - after release, results 1<<3, 1<<4, 1<<5 arrive in order with none lost or duplicated.
5. Reset mid-operation: full pipe with codes 10, 11; assert rst_n=0 for 1 cycle:
   - next edge gives out_valid=0 and out_data=0;
   - neither code emitted;
   - a new accept after reset gives its result 2 cycles later.
6. Mixed modes with IN_W=2: (code 2, mode 0), (code 2, mode 1), (code 3, mode 1) back-to-back -> 4'b0100, 4'b0111, 4'b1111.
